// File: rtl/param_seq_alu_md_if.sv
// rtl/param_seq_alu_md_if.sv - issue/result handshake bundle for the EX-stage ALU
//
// Groups the operand/issue side (in_*) and result side (out_*) of
// param_seq_alu_md.
//   slave  : the ALU (receives operands, drives result and flags)
//   master : the issuing stage / consumer (drives operands, accepts result)
// Signals:
//   in_valid/in_ready  issue handshake
//   rs1, rs2, imm_out  operands (B = ex_alu_src ? imm_out : rs2)
//   ex_alu_src         operand-B select
//   alu_ctrl           integer op code
//   md_en, md_func3    M-extension op select
//   out_valid/out_ready result handshake
//   result_alu, carry/zero/negative/overflow flags, busy
interface param_seq_alu_md_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] imm_out;
  logic            ex_alu_src;
  logic [3:0]      alu_ctrl;
  logic            md_en;
  logic [2:0]      md_func3;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result_alu;
  logic            carry_flag;
  logic            zero_flag;
  logic            negative_flag;
  logic            overflow_flag;
  logic            busy;

  modport slave (
    input  in_valid, rs1, rs2, imm_out, ex_alu_src, alu_ctrl, md_en, md_func3, out_ready,
    output in_ready, out_valid, result_alu, carry_flag, zero_flag, negative_flag,
           overflow_flag, busy
  );

  modport master (
    output in_valid, rs1, rs2, imm_out, ex_alu_src, alu_ctrl, md_en, md_func3, out_ready,
    input  in_ready, out_valid, result_alu, carry_flag, zero_flag, negative_flag,
           overflow_flag, busy
  );
endinterface

// File: rtl/param_seq_alu_md.sv
// rtl/param_seq_alu_md.sv - execute-stage ALU with iterative RV M-extension mul/div
//
// Single-cycle integer ops register their result in the accept cycle; MUL*/DIV*
// iterate XLEN cycles (shift-add multiply on magnitudes, restoring divide).
// Divide-by-zero and signed DIV/REM overflow bypass the iteration.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (kills any op, zeroes outputs)
//   flush  synchronous kill, priority over every other event
//   bus    param_seq_alu_md_if.slave issue/result bundle
// Optional feature macro: PARAM_ALU_EARLY_OUT_EN (multiply exits CALC once the
// remaining multiplier magnitude is zero).
module param_seq_alu_md #(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  param_seq_alu_md_if.slave    bus
);
  localparam int SHW = $clog2(XLEN);
  localparam int MSB = XLEN - 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [XLEN-1:0]   r_result;
  logic              r_carry, r_zero, r_neg_f, r_ovf;
  logic [2:0]        r_func;
  logic              r_neg;       // product / quotient must be negated
  logic              r_sign_a;    // remainder takes this sign
  logic [SHW-1:0]    r_cnt;
  logic [2*XLEN-1:0] r_acc;       // mul: partial product; div: remainder in low half
  logic [2*XLEN-1:0] r_mcand;     // mul: shifted multiplicand; div: divisor in low half
  logic [XLEN-1:0]   r_mplier;    // mul: shifting multiplier; div: dividend -> quotient

  logic              w_accept, w_in_ready, w_out_valid, w_busy;
  logic [XLEN-1:0]   w_a, w_b;

  assign w_a      = bus.rs1;
  assign w_b      = bus.ex_alu_src ? bus.imm_out : bus.rs2;
  assign w_accept = bus.in_valid && (r_state == S_IDLE) && !flush;

  // ---------------- single-cycle integer ops ----------------
  logic [XLEN:0]   w_sum, w_sub;
  logic [XLEN-1:0] w_alu_res;
  logic            w_alu_c, w_alu_v;

  assign w_sum = {1'b0, w_a} + {1'b0, w_b};
  assign w_sub = {1'b0, w_a} + {1'b0, ~w_b} + {{XLEN{1'b0}}, 1'b1};

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (bus.alu_ctrl)
      4'b0001: begin
        w_alu_res = w_sub[MSB:0];
        w_alu_c   = w_sub[XLEN];
        w_alu_v   = (w_a[MSB] != w_b[MSB]) && (w_sub[MSB] != w_a[MSB]);
      end
      4'b0010: w_alu_res = w_a & w_b;
      4'b0011: w_alu_res = w_a | w_b;
      4'b0100: w_alu_res = w_a ^ w_b;
      4'b0101: w_alu_res = w_a << w_b[SHW-1:0];
      4'b0110: w_alu_res = w_a >> w_b[SHW-1:0];
      4'b0111: w_alu_res = $signed(w_a) >>> w_b[SHW-1:0];
      4'b1000: w_alu_res = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      4'b1001: w_alu_res = {{(XLEN-1){1'b0}}, (w_a < w_b)};
      default: begin
        w_alu_res = w_sum[MSB:0];
        w_alu_c   = w_sum[XLEN];
        w_alu_v   = (w_a[MSB] == w_b[MSB]) && (w_sum[MSB] != w_a[MSB]);
      end
    endcase
  end

  // ---------------- M-extension decode ----------------
  logic            w_is_mul, w_is_div, w_div_signed, w_div_zero, w_div_ovf, w_go_calc;
  logic            w_sa, w_sb, w_sign_a, w_sign_b;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_div_fast_res, w_direct_res;

  assign w_is_mul     = bus.md_en && !bus.md_func3[2];
  assign w_is_div     = bus.md_en &&  bus.md_func3[2];
  assign w_div_signed = !bus.md_func3[0];
  assign w_div_zero   = (w_b == '0);
  assign w_div_ovf    = w_div_signed && (w_a == {1'b1, {(XLEN-1){1'b0}}}) && (w_b == '1);
  assign w_go_calc    = w_is_mul || (w_is_div && !w_div_zero && !w_div_ovf);

  // MULH: both signed, MULHSU: only A signed, MUL/MULHU: unsigned
  assign w_sa = w_is_div ? w_div_signed : (bus.md_func3[1:0] == 2'b01 || bus.md_func3[1:0] == 2'b10);
  assign w_sb = w_is_div ? w_div_signed : (bus.md_func3[1:0] == 2'b01);
  assign w_sign_a = w_sa && w_a[MSB];
  assign w_sign_b = w_sb && w_b[MSB];
  assign w_mag_a  = w_sign_a ? -w_a : w_a;
  assign w_mag_b  = w_sign_b ? -w_b : w_b;

  // divide by zero / signed overflow answers (func3[1] selects REM/REMU)
  always_comb begin
    w_div_fast_res = '0;
    if (w_div_zero) w_div_fast_res = bus.md_func3[1] ? w_a : '1;
    else            w_div_fast_res = bus.md_func3[1] ? '0  : w_a;
  end

  assign w_direct_res = bus.md_en ? w_div_fast_res : w_alu_res;

  // ---------------- iteration step ----------------
  logic [2*XLEN-1:0] w_acc_add, w_prod;
  logic [XLEN-1:0]   w_mplier_sh, w_rem_nxt, w_quo_nxt, w_mul_res, w_div_res, w_calc_res;
  logic [XLEN:0]     w_rem_sh, w_diff;
  logic              w_ge, w_calc_done;

  assign w_acc_add   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplier_sh = r_mplier >> 1;

  assign w_rem_sh  = {r_acc[MSB:0], r_mplier[MSB]};
  assign w_diff    = w_rem_sh - {1'b0, r_mcand[MSB:0]};
  assign w_ge      = !w_diff[XLEN];
  assign w_rem_nxt = w_ge ? w_diff[MSB:0] : w_rem_sh[MSB:0];
  assign w_quo_nxt = {r_mplier[MSB-1:0], w_ge};

`ifdef PARAM_ALU_EARLY_OUT_EN
  assign w_calc_done = (&r_cnt) || (!r_func[2] && (w_mplier_sh == '0));
`else
  assign w_calc_done = &r_cnt;
`endif

  assign w_prod     = r_neg ? -w_acc_add : w_acc_add;
  assign w_mul_res  = (r_func[1:0] == 2'b00) ? w_prod[MSB:0] : w_prod[2*XLEN-1:XLEN];
  assign w_div_res  = r_func[1] ? (r_sign_a ? -w_rem_nxt : w_rem_nxt)
                                : (r_neg    ? -w_quo_nxt : w_quo_nxt);
  assign w_calc_res = r_func[2] ? w_div_res : w_mul_res;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = rst_n;
        if (w_accept) w_state_nxt = w_go_calc ? S_CALC : S_DONE;
      end
      S_CALC: begin
        w_busy = 1'b1;
        if (w_calc_done) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_neg_f  <= 1'b0;
      r_ovf    <= 1'b0;
      r_func   <= '0;
      r_neg    <= 1'b0;
      r_sign_a <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (flush) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_func   <= bus.md_func3;
            r_neg    <= w_sign_a ^ w_sign_b;
            r_sign_a <= w_sign_a;
            r_cnt    <= '0;
            r_acc    <= '0;
            if (w_go_calc) begin
              if (w_is_mul) begin
                r_mcand  <= {{XLEN{1'b0}}, w_mag_a};
                r_mplier <= w_mag_b;
              end else begin
                r_mcand  <= {{XLEN{1'b0}}, w_mag_b};
                r_mplier <= w_mag_a;
              end
            end else begin
              r_result <= w_direct_res;
              r_carry  <= bus.md_en ? 1'b0 : w_alu_c;
              r_ovf    <= bus.md_en ? 1'b0 : w_alu_v;
              r_neg_f  <= w_direct_res[MSB];
              r_zero   <= (w_direct_res == '0);
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + SHW'(1);
          if (!r_func[2]) begin
            r_acc    <= w_acc_add;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_sh;
          end else begin
            r_acc    <= {{XLEN{1'b0}}, w_rem_nxt};
            r_mplier <= w_quo_nxt;
          end
          if (w_calc_done) begin
            r_result <= w_calc_res;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_neg_f  <= w_calc_res[MSB];
            r_zero   <= (w_calc_res == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = w_out_valid;
  assign bus.busy          = w_busy;
  assign bus.result_alu    = r_result;
  assign bus.carry_flag    = r_carry;
  assign bus.zero_flag     = r_zero;
  assign bus.negative_flag = r_neg_f;
  assign bus.overflow_flag = r_ovf;
endmodule
